// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if: command/result bus between the arbiter and a single i2c_master
interface i2c_arbiter_if;
    logic [6:0] m_chip_addr;
    logic [7:0] m_reg_addr;
    logic [7:0] m_data_in;
    logic       m_write_en;
    logic       m_read_en;
    logic       m_done;
    logic       m_busy;
    logic [7:0] m_data_out;
    logic [2:0] m_status;

    modport master (
        output m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en,
        input  m_done, m_busy, m_data_out, m_status
    );

    modport slave (
        input  m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en,
        output m_done, m_busy, m_data_out, m_status
    );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c_master among N_REQ requesters,
// with a saturating per-transaction timeout.
module i2c_arbiter #(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [7*N_REQ-1:0] req_chip_addr,
    input  logic [8*N_REQ-1:0] req_reg_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic [2:0]         rsp_status,
    i2c_arbiter_if.master      bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] last_grant, gnt_idx, cur;
    logic          gnt_found, cur_rw, grant, timeout;
    logic [CW-1:0] cnt;

    // Lowest offset from last_grant wins, so scan offsets from far to near.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx = last_grant;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[IW'((int'(last_grant) + k) % N_REQ)]) begin
                gnt_found = 1'b1;
                gnt_idx = IW'((int'(last_grant) + k) % N_REQ);
            end
        end
    end

    assign grant   = state == S_IDLE && gnt_found && !bus.m_busy;
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            last_grant <= IW'(N_REQ - 1);
            cur <= '0;
            cur_rw <= 1'b0;
            cnt <= '0;
            rsp_rdata <= 8'h00;
            rsp_status <= 3'h0;
            bus.m_chip_addr <= '0;
            bus.m_reg_addr <= '0;
            bus.m_data_in <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_grant <= gnt_idx;
                cur <= gnt_idx;
                cur_rw <= req_rw[gnt_idx];
                bus.m_chip_addr <= req_chip_addr[7*gnt_idx +: 7];
                bus.m_reg_addr <= req_reg_addr[8*gnt_idx +: 8];
                bus.m_data_in <= req_wdata[8*gnt_idx +: 8];
            end
            if (state == S_ISSUE)
                cnt <= '0;
            else if (state == S_WAIT && cnt != '1)
                cnt <= cnt + 1'b1;
            if (state == S_WAIT && (bus.m_done || timeout)) begin
                rsp_rdata <= bus.m_done ? bus.m_data_out : 8'h00;
                rsp_status <= bus.m_done ? bus.m_status : 3'b111;
            end
        end
    end

    always_comb begin
        state_nxt = grant ? S_ISSUE
                  : state == S_ISSUE ? S_WAIT
                  : (state == S_WAIT && (bus.m_done || timeout)) ? S_RESP
                  : state == S_RESP ? S_IDLE
                  : state;
    end

    // Strobes are gated by reset so an aborted transaction emits nothing.
    always_comb begin
        req_ack = (grant && reset) ? N_REQ'(1) << gnt_idx : '0;
        rsp_valid = (state == S_RESP && reset) ? N_REQ'(1) << cur : '0;
        bus.m_write_en = state == S_ISSUE && reset && !cur_rw;
        bus.m_read_en = state == S_ISSUE && reset && cur_rw;
    end
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: scoreboard bench; a round-robin reference model predicts grant
// order and responses, a monitor checks them as the DUT presents them.
module tb_i2c_arbiter;
    localparam int N     = 3;
    localparam int TO    = 16;
    localparam int NEVER = 255;

    typedef struct { int idx; int cyc; } ack_t;
    typedef struct { logic rw; logic [6:0] chip; logic [7:0] rg; logic [7:0] wd; } cmd_t;
    typedef struct { int j; logic [7:0] d; logic [2:0] s; } plan_t;
    typedef struct { int idx; logic [7:0] d; logic [2:0] s; } rsp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_rw = '0;
    logic [7*N-1:0] req_chip_addr = '0;
    logic [8*N-1:0] req_reg_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   req_ack, rsp_valid;
    logic [7:0]     rsp_rdata;
    logic [2:0]     rsp_status;

    i2c_arbiter_if bus();

    i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    ack_t  ack_q[$];
    cmd_t  cmd_q[$];
    plan_t plan_q[$];
    rsp_t  rsp_q[$];
    int    rsp_cyc_q[$];

    logic       f_rw[N];
    logic [6:0] f_chip[N];
    logic [7:0] f_rg[N];
    logic [7:0] f_wd[N];
    int         pj[N];
    logic [7:0] pd[N];
    logic [2:0] ps[N];
    int         mlast = N - 1;
    int         last_rsp = -100;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            req_rw[i] = f_rw[i];
            req_chip_addr[7*i +: 7] = f_chip[i];
            req_reg_addr[8*i +: 8] = f_rg[i];
            req_wdata[8*i +: 8] = f_wd[i];
        end
    endtask

    task automatic rand_fields(input int i);
        f_rw[i] = 1'($urandom);
        f_chip[i] = 7'($urandom);
        f_rg[i] = 8'($urandom);
        f_wd[i] = 8'($urandom);
    endtask

    task automatic rand_plans();
        for (int p = 0; p < N; p++) begin
            pj[p] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 17));
            pd[p] = 8'($urandom);
            ps[p] = 3'($urandom_range(0, 6));
        end
    endtask

    task automatic check_reset_values();
        chk("rst_req_ack", req_ack, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_status", rsp_status, 0);
        chk("rst_write_en", bus.m_write_en, 0);
        chk("rst_read_en", bus.m_read_en, 0);
        chk("rst_chip_addr", bus.m_chip_addr, 0);
        chk("rst_reg_addr", bus.m_reg_addr, 0);
        chk("rst_data_in", bus.m_data_in, 0);
    endtask

    // One round: requesters in mask raise req_valid together, those in drop
    // withdraw one cycle later, m_busy is held for b cycles at the start.
    task automatic do_round(input logic [N-1:0] mask, input logic [N-1:0] drop, input int b);
        int order[$];
        int c;
        logic [N-1:0] pend, ackd;
        bit done;
        pend = mask & ~drop;
        for (int k = 1; k <= N; k++)
            if (pend[(mlast + k) % N]) order.push_back((mlast + k) % N);
        @(posedge clk); #1;
        c = cyc;
        foreach (order[p]) begin
            int i;
            bit ok;
            i = order[p];
            ok = pj[p] <= TO - 1;
            ack_q.push_back('{i, p == 0 ? c + b : -1});
            cmd_q.push_back('{f_rw[i], f_chip[i], f_rg[i], f_wd[i]});
            plan_q.push_back('{pj[p], pd[p], ps[p]});
            rsp_q.push_back('{i, ok ? pd[p] : 8'h00, ok ? ps[p] : 3'b111});
        end
        if (order.size() > 0) mlast = order[order.size() - 1];
        drive_fields();
        req_valid = mask;
        bus.m_busy = b > 0;
        done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            ackd = req_ack;
            @(posedge clk); #1;
            req_valid &= ~ackd;
            if (t == 0) req_valid &= ~drop;
            bus.m_busy = t + 1 < b;
            for (int i = 0; i < N; i++) if (ackd[i]) rand_fields(i);
            drive_fields();
            done = t + 1 >= b + 2 && ack_q.size() == 0 && rsp_q.size() == 0;
        end
        if (!done) begin
            chk("round_timeout_pending", ack_q.size() + rsp_q.size(), 0);
            ack_q.delete(); cmd_q.delete(); plan_q.delete(); rsp_q.delete(); rsp_cyc_q.delete();
        end
        req_valid = '0;
    endtask

    // Monitor: pops expectations whenever the DUT pulses req_ack or rsp_valid.
    ack_t mon_a;
    rsp_t mon_r;
    int   mon_c;
    always @(negedge clk) begin
        if (reset) begin
            if (req_ack != '0) begin
                chk("ack_onehot", 64'($onehot(req_ack)), 1);
                if (ack_q.size() == 0) chk("ack_unexpected", req_ack, 0);
                else begin
                    mon_a = ack_q.pop_front();
                    chk("ack_idx", req_ack, 1 << mon_a.idx);
                    chk("ack_cycle", cyc, mon_a.cyc >= 0 ? mon_a.cyc : last_rsp + 1);
                end
            end
            if (rsp_valid != '0) begin
                chk("rsp_onehot", 64'($onehot(rsp_valid)), 1);
                if (rsp_q.size() == 0 || rsp_cyc_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    mon_r = rsp_q.pop_front();
                    mon_c = rsp_cyc_q.pop_front();
                    chk("rsp_idx", rsp_valid, 1 << mon_r.idx);
                    chk("rsp_rdata", rsp_rdata, mon_r.d);
                    chk("rsp_status", rsp_status, mon_r.s);
                    chk("rsp_cycle", cyc, mon_c);
                end
                last_rsp = cyc;
            end
        end
    end

    // i2c_master model: answers each strobe per the next plan entry.
    plan_t m_pl;
    cmd_t  m_cm;
    initial begin
        bus.m_done = 1'b0;
        bus.m_busy = 1'b0;
        bus.m_data_out = 8'h00;
        bus.m_status = 3'h0;
        forever begin
            @(posedge clk); #1;
            bus.m_done = 1'b0;
            bus.m_data_out = 8'($urandom);
            bus.m_status = 3'($urandom);
            if (reset && (bus.m_write_en || bus.m_read_en)) begin
                if (plan_q.size() == 0 || cmd_q.size() == 0)
                    chk("strobe_unexpected", {bus.m_read_en, bus.m_write_en}, 0);
                else begin
                    m_pl = plan_q.pop_front();
                    m_cm = cmd_q.pop_front();
                    chk("strobe_dir", {bus.m_read_en, bus.m_write_en}, m_cm.rw ? 2'b10 : 2'b01);
                    chk("cmd_chip", bus.m_chip_addr, m_cm.chip);
                    chk("cmd_reg", bus.m_reg_addr, m_cm.rg);
                    chk("cmd_wdata", bus.m_data_in, m_cm.wd);
                    rsp_cyc_q.push_back(m_pl.j <= TO - 1 ? cyc + 2 + m_pl.j : cyc + TO + 1);
                    if (m_pl.j != NEVER) begin
                        for (int i = 0; i <= m_pl.j; i++) begin @(posedge clk); #1; end
                        if (m_pl.j <= TO - 1) begin
                            chk("hold_chip", bus.m_chip_addr, m_cm.chip);
                            chk("hold_reg", bus.m_reg_addr, m_cm.rg);
                            chk("hold_wdata", bus.m_data_in, m_cm.wd);
                        end
                        bus.m_done = 1'b1;
                        bus.m_data_out = m_pl.d;
                        bus.m_status = m_pl.s;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] m, dr;
        int b;
        for (int i = 0; i < N; i++) rand_fields(i);
        drive_fields();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b1;

        // all three held, 10-cycle master latency: order 0,1,2 then 0 again
        for (int p = 0; p < N; p++) begin pj[p] = 10; pd[p] = 8'($urandom); ps[p] = 3'($urandom_range(0, 6)); end
        do_round(3'b111, 3'b000, 0);
        do_round(3'b111, 3'b000, 0);

        // requester 1 read from chip 0x39
        f_rw[1] = 1'b1; f_chip[1] = 7'h39; f_rg[1] = 8'h00;
        pj[0] = 3; pd[0] = 8'h13; ps[0] = 3'h0;
        do_round(3'b010, 3'b000, 0);

        // requester 0 write that the master never completes
        f_rw[0] = 1'b0; f_rg[0] = 8'hD6; f_wd[0] = 8'hC0;
        pj[0] = NEVER;
        do_round(3'b001, 3'b000, 0);

        // completion right at the timeout boundary and one cycle late
        pj[0] = TO - 1; pd[0] = 8'h5A; ps[0] = 3'h2;
        do_round(3'b100, 3'b000, 0);
        pj[0] = TO; pd[0] = 8'hA5; ps[0] = 3'h3;
        do_round(3'b010, 3'b000, 0);

        // m_busy blocks grants; a withdrawn request is never granted
        rand_plans();
        do_round(3'b001, 3'b000, 5);
        rand_plans();
        do_round(3'b011, 3'b010, 3);

        // reset during requester 2's wait aborts without a response
        f_rw[2] = 1'b0;
        drive_fields();
        @(posedge clk); #1;
        ack_q.push_back('{2, cyc});
        cmd_q.push_back('{f_rw[2], f_chip[2], f_rg[2], f_wd[2]});
        plan_q.push_back('{NEVER, 8'h00, 3'h0});
        req_valid = 3'b100;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b1;
        rsp_cyc_q.delete();
        mlast = N - 1;
        repeat (3) @(posedge clk);
        rand_plans();
        do_round(3'b101, 3'b000, 0);

        for (int r = 0; r < 40; r++) begin
            m = N'($urandom_range(1, 7));
            b = $urandom_range(0, 3);
            dr = b >= 2 ? m & N'($urandom) : '0;
            for (int i = 0; i < N; i++) rand_fields(i);
            rand_plans();
            do_round(m, dr, b);
        end

        repeat (5) @(posedge clk);
        chk("end_ack_q", ack_q.size(), 0);
        chk("end_rsp_q", rsp_q.size(), 0);
        chk("end_plan_q", plan_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters sharing one i2c_master (range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles to wait for m_done before abandoning a transaction.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester request pending; held until accepted.
REQ-006 SHALL have port req_rw  input  N_REQ  per-requester direction: 1 = read, 0 = write.
REQ-007 SHALL have port req_chip_addr  input  7*N_REQ  7-bit device address; requester i occupies bits [7i+6:7i].
REQ-008 SHALL have port req_reg_addr  input  8*N_REQ  register address, packed as 8i+7:8i.
REQ-009 SHALL have port req_wdata  input  8*N_REQ  write data, packed as 8i+7:8i.
REQ-010 SHALL have port req_ack  output  N_REQ  one-cycle pulse: request accepted; fields latched.
REQ-011 SHALL have port rsp_valid  output  N_REQ  one-cycle pulse: transaction finished for that requester.
REQ-012 SHALL have port rsp_rdata  output  8  read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_status  output  3  i2c status, or 3'b111 on timeout; valid with rsp_valid.
REQ-014 SHALL have ports m_chip_addr (output 7), m_reg_addr (output 8) and m_data_in (output 8), the command fields to i2c_master.
REQ-015 SHALL have ports m_write_en and m_read_en, each output 1, one-cycle start strobes to i2c_master.
REQ-016 SHALL have ports m_done (input 1), m_busy (input 1), m_data_out (input 8) and m_status (input 3), the results from i2c_master.

Function
REQ-017 SHALL implement FSM S_IDLE, S_ISSUE, S_WAIT, S_RESP.
REQ-018 In S_IDLE with any req_valid set and m_busy low, SHALL grant one requester by round-robin, pulse its req_ack, latch its fields, and go to S_ISSUE.
REQ-019 Round-robin SHALL search from (last_grant+1) mod N_REQ upward, wrapping; last_grant resets to N_REQ-1, so requester 0 has first priority.
REQ-020 In S_IDLE with m_busy high, SHALL grant nothing and pulse no req_ack.
REQ-021 In S_ISSUE, SHALL assert exactly one of m_write_en or m_read_en (per latched rw) for one cycle, clear the timeout counter, and go to S_WAIT.
REQ-022 m_chip_addr, m_reg_addr and m_data_in SHALL stay stable from S_ISSUE until leaving S_WAIT.
REQ-023 In S_WAIT, on m_done SHALL capture m_data_out and m_status and go to S_RESP.
REQ-024 In S_WAIT, when the counter reaches TIMEOUT_CYCLES-1 without m_done, SHALL set status 3'b111 and rdata 8'h00 and go to S_RESP.
REQ-025 The counter SHALL saturate, never wrap; its width SHALL be $clog2(TIMEOUT_CYCLES)+1.
REQ-026 In S_RESP, SHALL pulse rsp_valid only at the granted index for one cycle, then return to S_IDLE.
REQ-027 Request-to-next-grant minimum turnaround SHALL be 4 cycles: IDLE, ISSUE, WAIT (done same cycle), RESP.
REQ-028 Changes to req_valid or request fields of a granted requester after req_ack SHALL NOT affect the in-flight transaction.
REQ-029 A requester dropping req_valid before ack SHALL NOT be granted.
REQ-030 At most one req_ack bit and at most one rsp_valid bit SHALL be set in any cycle.
REQ-031 m_done arriving outside S_WAIT SHALL be ignored.

Reset
REQ-032 When reset is low at a clock edge, SHALL enter S_IDLE, and mid-transaction SHALL abort without emitting rsp_valid.
REQ-033 Reset values: req_ack=0, rsp_valid=0, rsp_rdata=8'h00, rsp_status=3'h0, m_write_en=0, m_read_en=0, m_chip_addr=0, m_reg_addr=0, m_data_in=0, last_grant=N_REQ-1, counter=0.

Verification
REQ-034 req_valid=3'b111 held, master model m_done 10 cycles after strobe -> grant order 0,1,2,0; each rsp_valid pulse single-cycle.
REQ-035 Requester 1 read, chip 7'h39, reg 8'h00, m_data_out=8'h13, m_status=3'h0 -> one m_read_en pulse, m_chip_addr=7'h39, then rsp_valid=3'b010, rsp_rdata=8'h13.
REQ-036 Requester 0 write reg 8'hD6 data 8'hC0, m_done never asserted, TIMEOUT_CYCLES=16 -> rsp_valid[0] after 16 cycles in S_WAIT, rsp_status=3'b111.
REQ-037 m_busy held high with req_valid=3'b001 -> no req_ack; m_busy drops -> req_ack=3'b001 next cycle.
REQ-038 reset low during S_WAIT of a requester 2 transaction -> no rsp_valid; after release, req_valid=3'b101 -> requester 0 granted first.
